// File: rtl/i2c_codec_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | i2c_codec_responder: write-only I2C target emulating the codec port      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_codec_responder #(
    parameter logic [7:0] DEV_ADDR   = 8'h34,
    parameter int         NUM_REGS   = 10,
    parameter int         FILTER_LEN = 4
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       FPGA_I2C_SCLK,
    inout  wire        FPGA_I2C_SDAT,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       frame_err,
    output logic       busy,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        SUB      = 3'd3,
        SUB_ACK  = 3'd4,
        DATA     = 3'd5,
        DATA_ACK = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    reg_default = 9'h097;
            2, 3:    reg_default = 9'h079;
            4:       reg_default = 9'h00A;
            5:       reg_default = 9'h008;
            6:       reg_default = 9'h09F;
            7:       reg_default = 9'h00A;
            default: reg_default = 9'h000;
        endcase
    endfunction

    logic [1:0] line_raw;
    logic       scl_f, sda_f;
    assign line_raw = {FPGA_I2C_SCLK, FPGA_I2C_SDAT};

    // Index 1 is SCL, index 0 is SDA; both idle high so reset to 1.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_line
            logic             s1, s2, filt;
            logic [CNT_W-1:0] cnt;
            always_ff @(posedge CLOCK_50) begin
                if (!resetn) begin
                    s1   <= 1'b1;
                    s2   <= 1'b1;
                    filt <= 1'b1;
                    cnt  <= '0;
                end else begin
                    s1 <= line_raw[g];
                    s2 <= s1;
                    if (s2 == filt) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                        filt <= s2;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign scl_f = g_line[1].filt;
    assign sda_f = g_line[0].filt;

    state_t     state;
    logic       scl_p, sda_p, sda_oe;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [6:0] sub_addr;
    logic       sub_d8;
    logic [7:0] data_lo;
    logic [8:0] regs [NUM_REGS];

    logic       scl_rise, scl_fall, start_c, stop_c, mid_frame;
    logic [7:0] byte_in;

    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_c   = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_c    = scl_f & scl_p & ~sda_p & sda_f;
    assign byte_in   = {shreg, sda_f};
    assign mid_frame = (state == SUB) || (state == SUB_ACK) ||
                       (state == DATA) || (state == DATA_ACK);

    assign FPGA_I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state     <= IDLE;
            scl_p     <= 1'b1;
            sda_p     <= 1'b1;
            sda_oe    <= 1'b0;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            sub_addr  <= 7'd0;
            sub_d8    <= 1'b0;
            data_lo   <= 8'd0;
            wr_valid  <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 9'd0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
        end else begin
            scl_p     <= scl_f;
            sda_p     <= sda_f;
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start_c) begin
                if (mid_frame) frame_err <= 1'b1;
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_c) begin
                // A STOP right after START (no address bits yet) is benign.
                if (mid_frame || (state == ADDR && bit_cnt != 3'd0)) frame_err <= 1'b1;
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR, SUB, DATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    state <= (byte_in == DEV_ADDR) ? ADDR_ACK : IGNORE;
                                end else if (state == SUB) begin
                                    sub_addr <= byte_in[7:1];
                                    sub_d8   <= byte_in[0];
                                    state    <= SUB_ACK;
                                end else begin
                                    data_lo <= byte_in;
                                    state   <= DATA_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, SUB_ACK, DATA_ACK: begin
                        // First fall starts the ACK, second fall ends it.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (state == ADDR_ACK) begin
                                    state <= SUB;
                                end else if (state == SUB_ACK) begin
                                    state <= DATA;
                                end else begin
                                    state    <= IGNORE;
                                    wr_valid <= 1'b1;
                                    wr_addr  <= sub_addr;
                                    wr_data  <= {sub_d8, data_lo};
                                    if (sub_addr == 7'h0F) begin
                                        for (int i = 0; i < NUM_REGS; i++)
                                            regs[i] <= reg_default(i);
                                    end else if (int'(sub_addr) < NUM_REGS) begin
                                        regs[sub_addr[IDX_W-1:0]] <= {sub_d8, data_lo};
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 9'd0;
        if (int'(rd_addr) < NUM_REGS) rd_data = regs[rd_addr[IDX_W-1:0]];
    end

endmodule
`default_nettype wire
